// File: rtl/pipeline_ctrl.sv
// Sequencing and hazard controller for the 5-stage MIPS pipeline: run/pause/step/halt-drain
// FSM plus load-use and branch hazard controls for PC, IF/ID and ID/EX.
//
// state  | meaning
// PAUSED | pipeline frozen, waiting for a debug command (reset state)
// RUN    | free running
// STEP   | single enabled cycle, then back to PAUSED
// DRAIN  | HALT left ID; clocking until the older instructions retire
// HALTED | drained after HALT; frozen until reset
module pipeline_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       ex_rt,
  input  logic             ex_mem_read,
  input  logic             id_branch_taken,
  input  logic             id_halt,
  input  logic             dbg_run,
  input  logic             dbg_step,
  input  logic             dbg_halt_req,
  output logic             pipe_en,
  output logic             pc_write,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic             step_done,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {PAUSED, RUN, STEP, DRAIN, HALTED} state_t;

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  state_t          state, state_next;
  logic [DW-1:0]   drain_cnt;
  logic            state_en;
  logic            load_use;

  always_comb begin
    state_next = state;
    case (state)
      PAUSED: begin
        if (dbg_run)       state_next = RUN;
        else if (dbg_step) state_next = STEP;
      end
      RUN: begin
        if (id_halt)           state_next = DRAIN;
        else if (dbg_halt_req) state_next = PAUSED;
      end
      STEP: begin
        if (id_halt) state_next = DRAIN;
        else         state_next = PAUSED;
      end
      DRAIN: begin
        if (drain_cnt == '0) state_next = HALTED;
      end
      HALTED:  state_next = HALTED;
      default: state_next = PAUSED;
    endcase
  end

  assign state_en = (state == RUN) || (state == STEP) || (state == DRAIN);
  // Gated by reset so the pipeline is frozen while reset is held, whatever state we were in.
  assign pipe_en  = state_en && !reset;
  assign halted   = (state == HALTED);

  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt)) && !id_halt;

  always_comb begin
    pc_write   = 1'b0;
    ifid_stall = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (pipe_en) begin
      ifid_stall = 1'b0;
      if (state == DRAIN) begin
        ifid_flush = 1'b1;
      end else if (load_use) begin
        // Load-use beats a taken branch: the branch operands are not ready yet.
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end else if (id_branch_taken) begin
        pc_write   = 1'b1;
        ifid_flush = 1'b1;
      end else if (id_halt) begin
        ifid_flush = 1'b1;
      end else begin
        pc_write   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= PAUSED;
      drain_cnt   <= '0;
      step_done   <= 1'b0;
      cycle_count <= '0;
    end else begin
      state     <= state_next;
      step_done <= (state == STEP) && (state_next == PAUSED);
      if (state_next == DRAIN && state != DRAIN)
        drain_cnt <= DRAIN_LOAD;
      else if (state == DRAIN && drain_cnt != '0)
        drain_cnt <= drain_cnt - 1'b1;
      if (pipe_en)
        cycle_count <= cycle_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl: reset, run/count, hazards, step,
// halt drain and reset during drain.
module tb_pipeline_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        ex_mem_read, id_branch_taken, id_halt;
  logic        dbg_run, dbg_step, dbg_halt_req;
  logic        pipe_en, pc_write, ifid_stall, ifid_flush, idex_flush, halted, step_done;
  logic [31:0] cycle_count;

  int errors = 0;
  int checks = 0;
  logic [31:0] c0;

  pipeline_ctrl #(.DRAIN_CYCLES(3), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt),
    .ex_mem_read(ex_mem_read), .id_branch_taken(id_branch_taken), .id_halt(id_halt),
    .dbg_run(dbg_run), .dbg_step(dbg_step), .dbg_halt_req(dbg_halt_req),
    .pipe_en(pipe_en), .pc_write(pc_write), .ifid_stall(ifid_stall),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .halted(halted),
    .step_done(step_done), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    ex_mem_read = 1'b0; id_branch_taken = 1'b0; id_halt = 1'b0;
    dbg_run = 1'b0; dbg_step = 1'b0; dbg_halt_req = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    checks++; if (pipe_en !== 1'b0) begin errors++; $display("FAIL reset_pipe_en got=%b exp=0", pipe_en); end
    checks++; if ({pc_write, ifid_stall, ifid_flush, idex_flush} !== 4'b0100) begin errors++;
      $display("FAIL reset_ctrl got=%b exp=0100", {pc_write, ifid_stall, ifid_flush, idex_flush}); end
    checks++; if ({halted, step_done} !== 2'b00) begin errors++;
      $display("FAIL reset_flags got=%b exp=00", {halted, step_done}); end
    checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", cycle_count); end
  endtask

  task automatic test_run_count();
    tick();
    dbg_run = 1'b1;
    #1;
    checks++; if (pipe_en !== 1'b0) begin errors++; $display("FAIL run_before got=%b exp=0", pipe_en); end
    tick();
    dbg_run = 1'b0;
    checks++; if (pipe_en !== 1'b1) begin errors++; $display("FAIL run_after got=%b exp=1", pipe_en); end
    checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL run_count0 got=%0d exp=0", cycle_count); end
    repeat (10) tick();
    checks++; if (cycle_count !== 32'd10) begin errors++; $display("FAIL run_count10 got=%0d exp=10", cycle_count); end
    checks++; if (pc_write !== 1'b1 || ifid_stall !== 1'b0) begin errors++;
      $display("FAIL run_idle got=%b%b exp=10", pc_write, ifid_stall); end
  endtask

  task automatic test_load_use();
    tick();
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_rt = 5'd9;
    #1;
    checks++; if ({pc_write, ifid_stall, idex_flush, ifid_flush} !== 4'b0110) begin errors++;
      $display("FAIL lu_rs got=%b exp=0110", {pc_write, ifid_stall, idex_flush, ifid_flush}); end
    tick();
    ex_rt = 5'd0; id_rs = 5'd0;
    #1;
    checks++; if ({pc_write, ifid_stall, idex_flush} !== 3'b100) begin errors++;
      $display("FAIL lu_r0 got=%b exp=100", {pc_write, ifid_stall, idex_flush}); end
    tick();
    ex_rt = 5'd9; id_rs = 5'd3;
    #1;
    checks++; if ({pc_write, ifid_stall, idex_flush} !== 3'b011) begin errors++;
      $display("FAIL lu_rt got=%b exp=011", {pc_write, ifid_stall, idex_flush}); end
    tick();
    ex_mem_read = 1'b0;
    #1;
    checks++; if ({pc_write, ifid_stall, idex_flush} !== 3'b100) begin errors++;
      $display("FAIL lu_noload got=%b exp=100", {pc_write, ifid_stall, idex_flush}); end
  endtask

  task automatic test_branch();
    tick();
    ex_mem_read = 1'b1; ex_rt = 5'd7; id_rs = 5'd7; id_branch_taken = 1'b1;
    #1;
    checks++; if ({pc_write, ifid_stall, idex_flush, ifid_flush} !== 4'b0110) begin errors++;
      $display("FAIL br_lu got=%b exp=0110", {pc_write, ifid_stall, idex_flush, ifid_flush}); end
    tick();
    ex_mem_read = 1'b0;
    #1;
    checks++; if ({pc_write, ifid_stall, idex_flush, ifid_flush} !== 4'b1001) begin errors++;
      $display("FAIL br_alone got=%b exp=1001", {pc_write, ifid_stall, idex_flush, ifid_flush}); end
    id_branch_taken = 1'b0; ex_mem_read = 1'b1; id_halt = 1'b1;
    #1;
    checks++; if ({pc_write, ifid_stall, idex_flush, ifid_flush} !== 4'b0001) begin errors++;
      $display("FAIL halt_masks_lu got=%b exp=0001", {pc_write, ifid_stall, idex_flush, ifid_flush}); end
    clear_inputs();
    tick();
    dbg_halt_req = 1'b1;
    tick();
    dbg_halt_req = 1'b0;
    checks++; if ({pipe_en, pc_write, ifid_stall} !== 3'b001) begin errors++;
      $display("FAIL pause got=%b exp=001", {pipe_en, pc_write, ifid_stall}); end
  endtask

  task automatic test_step();
    c0 = cycle_count;
    tick();
    dbg_step = 1'b1;
    tick();
    dbg_step = 1'b0;
    checks++; if ({pipe_en, step_done} !== 2'b10) begin errors++;
      $display("FAIL step_n1 got=%b exp=10", {pipe_en, step_done}); end
    tick();
    checks++; if ({pipe_en, step_done} !== 2'b01) begin errors++;
      $display("FAIL step_n2 got=%b exp=01", {pipe_en, step_done}); end
    checks++; if (cycle_count !== c0 + 32'd1) begin errors++;
      $display("FAIL step_count got=%0d exp=%0d", cycle_count, c0 + 32'd1); end
    tick();
    checks++; if ({pipe_en, step_done} !== 2'b00) begin errors++;
      $display("FAIL step_n3 got=%b exp=00", {pipe_en, step_done}); end
    dbg_run = 1'b1; dbg_step = 1'b1;
    tick();
    dbg_run = 1'b0; dbg_step = 1'b0;
    checks++; if (pipe_en !== 1'b1) begin errors++; $display("FAIL runstep_en got=%b exp=1", pipe_en); end
    tick();
    checks++; if ({pipe_en, step_done} !== 2'b10) begin errors++;
      $display("FAIL runstep_run got=%b exp=10", {pipe_en, step_done}); end
  endtask

  task automatic test_halt_drain();
    id_halt = 1'b1; dbg_halt_req = 1'b1;
    #1;
    checks++; if ({pc_write, ifid_flush} !== 2'b01) begin errors++;
      $display("FAIL halt_n got=%b exp=01", {pc_write, ifid_flush}); end
    tick();
    id_halt = 1'b0; dbg_halt_req = 1'b0;
    ex_mem_read = 1'b1; ex_rt = 5'd4; id_rs = 5'd4; dbg_run = 1'b1;
    c0 = cycle_count;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({pipe_en, pc_write, ifid_flush, ifid_stall, idex_flush, halted} !== 6'b101000) begin errors++;
        $display("FAIL drain_%0d got=%b exp=101000", i, {pipe_en, pc_write, ifid_flush, ifid_stall, idex_flush, halted}); end
      tick();
    end
    checks++; if ({halted, pipe_en} !== 2'b10) begin errors++;
      $display("FAIL halted got=%b exp=10", {halted, pipe_en}); end
    checks++; if (cycle_count !== c0 + 32'd3) begin errors++;
      $display("FAIL drain_count got=%0d exp=%0d", cycle_count, c0 + 32'd3); end
    dbg_step = 1'b1;
    tick(); tick();
    clear_inputs();
    checks++; if ({halted, pipe_en, ifid_stall} !== 3'b101) begin errors++;
      $display("FAIL halted_sticky got=%b exp=101", {halted, pipe_en, ifid_stall}); end
  endtask

  task automatic test_reset_mid_drain();
    reset = 1'b1; tick(); reset = 1'b0;
    dbg_run = 1'b1; tick(); dbg_run = 1'b0;
    id_halt = 1'b1; tick(); id_halt = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    checks++; if ({pipe_en, ifid_stall} !== 2'b01) begin errors++;
      $display("FAIL rst_during got=%b exp=01", {pipe_en, ifid_stall}); end
    tick();
    reset = 1'b0;
    checks++; if ({pipe_en, halted, cycle_count} !== 34'd0) begin errors++;
      $display("FAIL rst_drain en=%b halted=%b count=%0d exp 0/0/0", pipe_en, halted, cycle_count); end
    tick(); tick();
    checks++; if ({pipe_en, halted} !== 2'b00) begin errors++;
      $display("FAIL rst_paused got=%b exp=00", {pipe_en, halted}); end
  endtask

  task automatic test_step_halt();
    dbg_step = 1'b1; tick(); dbg_step = 1'b0;
    id_halt = 1'b1;
    #1;
    checks++; if ({pipe_en, pc_write, ifid_flush} !== 3'b101) begin errors++;
      $display("FAIL stephalt_n got=%b exp=101", {pipe_en, pc_write, ifid_flush}); end
    tick();
    id_halt = 1'b0;
    checks++; if ({pipe_en, step_done, ifid_flush} !== 3'b101) begin errors++;
      $display("FAIL stephalt_drain got=%b exp=101", {pipe_en, step_done, ifid_flush}); end
    tick(); tick(); tick();
    checks++; if ({halted, pipe_en, cycle_count} !== {2'b10, 32'd4}) begin errors++;
      $display("FAIL stephalt_end halted=%b en=%b count=%0d exp 1/0/4", halted, pipe_en, cycle_count); end
  endtask

  initial begin
    test_reset();
    test_run_count();
    test_load_use();
    test_branch();
    test_step();
    test_halt_drain();
    test_reset_mid_drain();
    test_step_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
